// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch slice. These include the FSM state
// encoding, the misaligned-redirect exception vector, the word widths, the
// prefetch queue entry layout and the PC increment helper.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int XLEN = 32;  // address / PC width
  localparam int ILEN = 32;  // instruction word width

  // PC loaded in place of a misaligned redirect target (alignment check build only).
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0004;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,  // one idle cycle after reset
    ST_RUN  = 2'd1,  // fetching
    ST_HOLD = 2'd2   // fetch_en low: PC frozen, queue drains
  } fetch_state_e;

  // One prefetch queue slot: the fetched word and its fetch address + 4.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc_plus_4;
  } fq_entry_t;

  // Sequential PC. The addition wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundle of the fetch unit's control, instruction memory and decode-side
// handshake signals.
//   master : the fetch unit
//            (drives imem_addr, out_valid, out_instr, out_pc_plus_4[, fetch_exc])
//   slave  : the surrounding pipeline / memory
//            (drives fetch_en, redirect_*, imem_rdata, out_ready)
// Macro FETCH_ALIGN_CHECK_EN adds the fetch_exc signal.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            fetch_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc_plus_4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            fetch_exc;

  modport master (
    input  fetch_en, redirect_valid, redirect_target, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc_plus_4, fetch_exc
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_target, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc_plus_4, fetch_exc
  );
`else
  modport master (
    input  fetch_en, redirect_valid, redirect_target, imem_rdata, out_ready,
    output imem_addr, out_valid, out_instr, out_pc_plus_4
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_target, imem_rdata, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc_plus_4
  );
`endif

endinterface : fetch_unit_if

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Circular prefetch FIFO of fq_entry_t. Flush empties the queue in one cycle.
// Parameters:
//   DEPTH      number of entries (power of two, 2..16)
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; clears pointers and count only
//   flush      discard every entry (takes priority over push/pop)
//   push       write push_data at tail
//   pop        advance head (caller guarantees count != 0)
//   push_data  entry to write
//   head_data  entry at head (valid only while count != 0)
//   count      number of occupied entries, 0..DEPTH
//   full       count == DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fq_entry_t              push_data,
  output fq_entry_t              head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            do_push;
  logic            do_pop;

  // Flush overrides both queue operations.
  assign do_push = push && !flush;
  assign do_pop  = pop  && !flush;

  // NOTE: storage has no reset branch. Only pointers and count decide what is
  // valid, so clearing the array would add reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= push_data;
    end
  end

  // Pointers are AW bits wide, so the increment wraps modulo DEPTH on its own.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;  // idle, or push and pop together
      endcase
    end
  end

  assign head_data = mem[head];
  assign full      = (count == FULL_COUNT);

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. The unit holds the PC, runs the BOOT/RUN/HOLD control
// FSM and handles redirects. It feeds a prefetch queue (fetch_queue) that
// presents instructions to decode through a valid/ready handshake.
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     prefetch queue entries (power of two, 2..16)
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   bus       fetch_unit_if.master. The bus carries these signals:
//               fetch_en, redirect_valid, redirect_target  (in)
//               imem_addr (out) / imem_rdata (in, combinational from imem_addr)
//               out_valid, out_instr, out_pc_plus_4 (out) / out_ready (in)
//               fetch_exc (out, FETCH_ALIGN_CHECK_EN builds only)
// Configuration:
//   FETCH_ALIGN_CHECK_EN  defined: a redirect target with bits [1:0] != 0 pulses
//                         fetch_exc for one cycle and loads PC = EXC_VECTOR.
//                         undefined: target bits [1:0] are forced to 00.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_pc;
  logic            redir;
  logic            fetch;
  logic            pop;
  logic            q_full;
  logic [CW-1:0]   q_count;
  fq_entry_t       q_push_data;
  fq_entry_t       q_head;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            misaligned;
  logic            fetch_exc_q;
`endif

  // The FSM ignores redirects in BOOT, when the PC has only just been loaded.
  assign redir = bus.redirect_valid && (state != ST_BOOT);

  // Nothing is handed to decode in a redirect cycle, so no pop happens there.
  assign bus.out_valid = (q_count != '0) && !redir;
  assign pop           = bus.out_valid && bus.out_ready;

  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign fetch = (state == ST_RUN) && bus.fetch_en && !redir && (!q_full || pop);

  // NOTE: every variable written here gets a default first. A path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    redirect_pc = bus.redirect_target & ~XLEN'(3);
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned = (bus.redirect_target[1:0] != 2'b00);
    if (misaligned) redirect_pc = EXC_VECTOR;
`endif
  end

  // NOTE: state registers use non-blocking assignments. All of them then update
  // together at the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_exc_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (!bus.fetch_en) state <= ST_HOLD;
        ST_HOLD: if (bus.fetch_en)  state <= ST_RUN;
        default: state <= ST_BOOT;
      endcase

      // A redirect wins over the sequential fetch. The new PC is presented to
      // memory in the following cycle.
      if (redir) begin
        pc <= redirect_pc;
      end else if (fetch) begin
        pc <= pc_incr(pc);
      end

`ifdef FETCH_ALIGN_CHECK_EN
      fetch_exc_q <= redir && misaligned;
`endif
    end
  end

  assign q_push_data.instr     = bus.imem_rdata;
  assign q_push_data.pc_plus_4 = pc_incr(pc);

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redir),
    .push      (fetch),
    .pop       (pop),
    .push_data (q_push_data),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full)
  );

  assign bus.imem_addr     = pc;
  assign bus.out_instr     = q_head.instr;
  assign bus.out_pc_plus_4 = q_head.pc_plus_4;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fetch_exc     = fetch_exc_q;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with RESET_PC=0 and DEPTH=4. Instruction memory
// returns its own address as the instruction word. The bench drives inputs 1ns
// after each rising edge and samples 3ns after it.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = bus.imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, then release. The caller ends up in the BOOT cycle.
  task automatic apply_reset(input logic ready);
    bus.fetch_en        = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.out_ready       = ready;
    reset               = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance until out_valid is seen, for at most max_cycles cycles.
  task automatic wait_valid(input int max_cycles, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      #2;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: out_valid not seen within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    #2;  // BOOT cycle
    total++; if (dut.state !== ST_BOOT) begin bad++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_BOOT); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", bus.imem_addr); end
    total++; if (dut.u_queue.count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.u_queue.count); end
`ifdef FETCH_ALIGN_CHECK_EN
    total++; if (bus.fetch_exc !== 1'b0) begin bad++; $display("FAIL reset_exc: got %b want 0", bus.fetch_exc); end
`endif
    tick();
    #2;  // first fetch cycle
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fetch1_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL fetch1_pc: got %h want 00000000", bus.imem_addr); end
  endtask

  // One instruction per cycle from the third cycle after reset.
  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      tick();
      #2;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.out_valid); end
      total++; if (bus.out_instr !== 32'(4 * k)) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, bus.out_instr, 32'(4 * k)); end
      total++; if (bus.out_pc_plus_4 !== 32'(4 * k + 4)) begin bad++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, bus.out_pc_plus_4, 32'(4 * k + 4)); end
    end
  endtask

  // Decode stalled from reset: the queue fills and the PC stops. After release
  // the stream continues with nothing lost or duplicated.
  task automatic test_stall();
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) tick();
    #2;
    total++; if (dut.u_queue.count !== 3'd4) begin bad++; $display("FAIL stall_count: got %0d want 4", dut.u_queue.count); end
    total++; if (bus.imem_addr !== 32'h10) begin bad++; $display("FAIL stall_pc: got %h want 00000010", bus.imem_addr); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL stall_head: got %h want 00000000", bus.out_instr); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      bus.out_ready = 1'b1;
      #2;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL release_valid[%0d]: got %b want 1", k, bus.out_valid); end
      total++; if (bus.out_instr !== 32'(4 * k)) begin bad++; $display("FAIL release_instr[%0d]: got %h want %h", k, bus.out_instr, 32'(4 * k)); end
    end
  endtask

  // Redirect to 0x40 with a full queue at cycle N.
  task automatic test_redirect_full();
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    #2;
    total++; if (dut.u_queue.count !== 3'd4) begin bad++; $display("FAIL redir_full_count: got %0d want 4", dut.u_queue.count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_n_valid: got %b want 0", bus.out_valid); end
    tick();
    bus.redirect_valid = 1'b0;
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL redir_n1_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.imem_addr !== 32'h40) begin bad++; $display("FAIL redir_n1_pc: got %h want 00000040", bus.imem_addr); end
    tick();
    #2;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL redir_n2_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h40) begin bad++; $display("FAIL redir_n2_instr: got %h want 00000040", bus.out_instr); end
    total++; if (bus.out_pc_plus_4 !== 32'h44) begin bad++; $display("FAIL redir_n2_pc4: got %h want 00000044", bus.out_pc_plus_4); end
  endtask

  // Two entries (0x44, 0x48) queued with PC at 0x4C, then fetch_en dropped.
  task automatic test_hold();
    tick();
    bus.out_ready = 1'b0;  // 0x44 at head, 0x48 fetched behind it
    #2;
    total++; if (bus.out_instr !== 32'h44) begin bad++; $display("FAIL hold_pre_instr: got %h want 00000044", bus.out_instr); end
    tick();
    bus.fetch_en  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    total++; if (dut.u_queue.count !== 3'd2) begin bad++; $display("FAIL hold_count: got %0d want 2", dut.u_queue.count); end
    total++; if (bus.out_instr !== 32'h44) begin bad++; $display("FAIL hold_drain0: got %h want 00000044", bus.out_instr); end
    total++; if (bus.imem_addr !== 32'h4C) begin bad++; $display("FAIL hold_pc0: got %h want 0000004c", bus.imem_addr); end
    tick();
    #2;
    total++; if (bus.out_instr !== 32'h48) begin bad++; $display("FAIL hold_drain1: got %h want 00000048", bus.out_instr); end
    total++; if (bus.imem_addr !== 32'h4C) begin bad++; $display("FAIL hold_pc1: got %h want 0000004c", bus.imem_addr); end
    tick();
    tick();
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hold_empty: got %b want 0", bus.out_valid); end
    total++; if (bus.imem_addr !== 32'h4C) begin bad++; $display("FAIL hold_pc2: got %h want 0000004c", bus.imem_addr); end
    total++; if (dut.state !== ST_HOLD) begin bad++; $display("FAIL hold_state: got %0d want %0d", dut.state, ST_HOLD); end
    bus.fetch_en = 1'b1;
    wait_valid(6, "hold_resume_wait");
    total++; if (bus.out_instr !== 32'h4C) begin bad++; $display("FAIL hold_resume_instr: got %h want 0000004c", bus.out_instr); end
    total++; if (bus.out_pc_plus_4 !== 32'h50) begin bad++; $display("FAIL hold_resume_pc4: got %h want 00000050", bus.out_pc_plus_4); end
    tick();
    #2;
    total++; if (bus.out_instr !== 32'h50) begin bad++; $display("FAIL hold_resume_next: got %h want 00000050", bus.out_instr); end
  endtask

  // Misaligned redirect to 0x42, taken while in HOLD.
  task automatic test_align();
    logic [31:0] exp_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_pc = EXC_VECTOR;
`else
    exp_pc = 32'h40;
`endif
    bus.fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL align_drained: got %b want 0", bus.out_valid); end
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h42;
    tick();
    bus.redirect_valid = 1'b0;
    #2;
    total++; if (bus.imem_addr !== exp_pc) begin bad++; $display("FAIL align_pc: got %h want %h", bus.imem_addr, exp_pc); end
`ifdef FETCH_ALIGN_CHECK_EN
    total++; if (bus.fetch_exc !== 1'b1) begin bad++; $display("FAIL align_exc_pulse: got %b want 1", bus.fetch_exc); end
`endif
    tick();
    #2;
    total++; if (bus.imem_addr !== exp_pc) begin bad++; $display("FAIL align_pc_held: got %h want %h", bus.imem_addr, exp_pc); end
`ifdef FETCH_ALIGN_CHECK_EN
    total++; if (bus.fetch_exc !== 1'b0) begin bad++; $display("FAIL align_exc_end: got %b want 0", bus.fetch_exc); end
`endif
    bus.fetch_en = 1'b1;
    wait_valid(6, "align_resume_wait");
    total++; if (bus.out_instr !== exp_pc) begin bad++; $display("FAIL align_instr: got %h want %h", bus.out_instr, exp_pc); end
  endtask

  // The PC wraps from 0xFFFF_FFFC to 0.
  task automatic test_wrap();
    tick();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    #2;
    total++; if (bus.out_instr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_instr0: got %h want fffffff8", bus.out_instr); end
    tick();
    #2;
    total++; if (bus.out_instr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_instr1: got %h want fffffffc", bus.out_instr); end
    total++; if (bus.out_pc_plus_4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 00000000", bus.out_pc_plus_4); end
    tick();
    #2;
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL wrap_instr2: got %h want 00000000", bus.out_instr); end
  endtask

  // Reset with three entries queued and a redirect pending in the same cycle.
  task automatic test_reset_midstream();
    tick();
    bus.out_ready = 1'b0;
    tick();
    tick();
    #2;
    total++; if (dut.u_queue.count !== 3'd3) begin bad++; $display("FAIL mid_count_pre: got %0d want 3", dut.u_queue.count); end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h80;
    reset               = 1'b1;
    tick();
    reset              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    #2;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL mid_pc: got %h want 00000000", bus.imem_addr); end
    total++; if (dut.state !== ST_BOOT) begin bad++; $display("FAIL mid_state: got %0d want %0d", dut.state, ST_BOOT); end
    total++; if (dut.u_queue.count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", dut.u_queue.count); end
    tick();
    tick();
    #2;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_restart_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL mid_restart_instr: got %h want 00000000", bus.out_instr); end
  endtask

  initial begin
    reset               = 1'b1;
    bus.fetch_en        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.out_ready       = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_hold();
    test_align();
    test_wrap();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 fetch_en  input  1  permits new fetches; 0 holds PC, queue drains normally.
REQ-006 redirect_valid  input  1  branch/jump/jr taken; flush and refetch.
REQ-007 redirect_target  input  32  new PC for redirect.
REQ-008 imem_addr  output  32  instruction memory address, equal to current PC.
REQ-009 imem_rdata  input  32  instruction word, combinational from imem_addr in the same cycle.
REQ-010 out_valid  output  1  queue head holds a valid instruction for ID.
REQ-011 out_ready  input  1  ID accepts the head; low means stall.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc_plus_4  output  32  head fetch address + 4.
REQ-014 fetch_exc  output  1  one-cycle misaligned-redirect pulse (present only with macro).

Function
REQ-015 States BOOT, RUN, HOLD; BOOT lasts exactly one cycle after reset, then RUN.
REQ-016 RUN -> HOLD when fetch_en=0; HOLD -> RUN when fetch_en=1; redirect permitted in any state except BOOT.
REQ-017 Fetch occurs in RUN when count<DEPTH, or count==DEPTH with a pop in the same cycle; fetch writes {imem_rdata, PC+4} at tail and PC <= PC+4.
REQ-018 Pop occurs when out_valid & out_ready; head advances.
REQ-019 out_valid = (count!=0) & ~redirect_valid; no pop is counted in a redirect cycle.
REQ-020 Head/tail pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits; simultaneous push and pop leave count unchanged.
REQ-021 Redirect at cycle N: all entries discarded, no push at N, PC <= redirect_target at N+1, target instruction out_valid at N+2.
REQ-022 Redirect while full or in HOLD still flushes and loads PC; fetching resumes per state.
REQ-023 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-024 Queue entries are not reset-cleared; only pointers, count, PC and state are.

Reset
REQ-025 On reset: PC=RESET_PC, count=0, pointers=0, state=BOOT, out_valid=0, fetch_exc=0; out_instr/out_pc_plus_4 don't-care while out_valid=0.
REQ-026 Reset overrides redirect, push and pop in the same cycle; reset mid-stream discards all entries.
REQ-027 First instruction (RESET_PC) appears with out_valid=1 on the third cycle after reset deasserts (BOOT, fetch, present).

Configuration
REQ-028 Macro FETCH_ALIGN_CHECK_EN defined: redirect_target[1:0]!=0 pulses fetch_exc for one cycle, flushes, and loads PC=32'h8000_0004 instead of the target.
REQ-029 Macro undefined: fetch_exc port absent; redirect_target[1:0] ignored and forced to 00.

Structure
REQ-030 Shared package holds state encoding (BOOT/RUN/HOLD), EXC_VECTOR 32'h8000_0004, and instruction word width.
REQ-031 One sub-module fetch_queue (storage, pointers, count, push/pop/flush); fetch_unit holds PC, FSM, redirect logic.

Verification
REQ-032 Reset, RESET_PC=0, imem word = address, out_ready=1 -> out_instr 0,4,8,... one per cycle from the third cycle, out_pc_plus_4 = instr+4.
REQ-033 out_ready=0 for 10 cycles -> count saturates at 4, PC stops at 0x10, no entry lost or duplicated after release.
REQ-034 redirect_valid with target 0x40 at cycle N, queue full -> out_valid 0 at N and N+1, out_instr 0x40 at N+2.
REQ-035 fetch_en=0 with 2 entries queued -> both drain, then out_valid=0, PC constant; fetch_en=1 resumes at next sequential address.
REQ-036 With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fetch_exc=1 one cycle, next out_instr from 0x8000_0004; without macro -> fetch from 0x40.
REQ-037 Reset asserted with 3 entries queued and redirect pending -> next cycle out_valid=0, PC=RESET_PC, state BOOT.
